// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard: mirrors the in-flight instructions after ID and
// decides ID stall plus the registered bypass selects for the instruction entering EX.
module pipe_scoreboard #(
   parameter int DEPTH     = 3,
   parameter int FLUSH_AGE = 2,
   parameter int LW        = 2,
   parameter int SW        = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [4:0]    id_rs1,
   input  logic [4:0]    id_rs2,
   input  logic          id_use_rs1,
   input  logic          id_use_rs2,
   input  logic [4:0]    id_rd,
   input  logic          id_we,
   input  logic [LW-1:0] id_rdy,
   input  logic          hold,
   input  logic          flush,
   output logic          stall,
   output logic [SW-1:0] fwd_sel_rs1,
   output logic [SW-1:0] fwd_sel_rs2,
   output logic [SW-1:0] inflight
);

   // Slot DEPTH is never matched, so only its valid bit is kept (for inflight).
   logic [DEPTH:1]             r_v;
   logic [DEPTH-1:1]           r_we;
   logic [DEPTH-1:1][4:0]      r_rd;
   logic [DEPTH-1:1][LW-1:0]   r_rdy;
   logic [SW-1:0]              r_fwd1;
   logic [SW-1:0]              r_fwd2;

   logic [DEPTH:1]             w_nv;
   logic [DEPTH-1:1]           w_nwe;
   logic [DEPTH-1:1][4:0]      w_nrd;
   logic [DEPTH-1:1][LW-1:0]   w_nrdy;
   logic [SW:0]                w_lk1;
   logic [SW:0]                w_lk2;
   logic                       w_issue;
   logic [SW-1:0]              w_cnt;

   // Youngest producer wins: scan oldest to youngest so the smallest k is kept.
   // Returns {stall_request, next_fwd_sel}.
   function automatic logic [SW:0] lookup(
      input logic [4:0]                  src,
      input logic                        use_s,
      input logic [DEPTH-1:1]            v,
      input logic [DEPTH-1:1]            we,
      input logic [DEPTH-1:1][4:0]       rd,
      input logic [DEPTH-1:1][LW-1:0]    rdy
   );
      logic          req;
      logic [SW-1:0] sel;
      req = 1'b0;
      sel = '0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (use_s && v[k] && we[k] && (rd[k] == src) && (rd[k] != 5'd0)) begin
            req = (k + 1) < int'(rdy[k]);
            sel = req ? '0 : SW'(k + 1);
         end
      end
      return {req, sel};
   endfunction

   always_comb begin
      w_lk1 = lookup(id_rs1, id_use_rs1, r_v[DEPTH-1:1], r_we, r_rd, r_rdy);
      w_lk2 = lookup(id_rs2, id_use_rs2, r_v[DEPTH-1:1], r_we, r_rd, r_rdy);
   end

   assign stall   = id_valid & (w_lk1[SW] | w_lk2[SW]) & ~flush & rst;
   assign w_issue = id_valid & ~stall & ~flush;

   // Next slot contents: slot 1 from ID or a bubble; flush kills slots younger than FLUSH_AGE.
   always_comb begin
      w_nv      = '0;
      w_nwe     = '0;
      w_nrd     = '0;
      w_nrdy    = '0;
      w_nv[1]   = w_issue;
      w_nwe[1]  = id_we;
      w_nrd[1]  = id_rd;
      w_nrdy[1] = id_rdy;
      for (int k = 2; k <= DEPTH; k++) begin
         w_nv[k] = r_v[k-1] & ~(flush && ((k - 1) < FLUSH_AGE));
      end
      for (int k = 2; k <= DEPTH - 1; k++) begin
         w_nwe[k]  = r_we[k-1];
         w_nrd[k]  = r_rd[k-1];
         w_nrdy[k] = r_rdy[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_v    <= '0;
         r_fwd1 <= '0;
         r_fwd2 <= '0;
      end else if (!hold) begin
         r_v    <= w_nv;
         r_fwd1 <= w_issue ? w_lk1[SW-1:0] : '0;
         r_fwd2 <= w_issue ? w_lk2[SW-1:0] : '0;
      end
   end

   // Payload fields carry no reset; they are qualified by r_v.
   always_ff @(posedge clk) begin
      if (!hold) begin
         r_we  <= w_nwe;
         r_rd  <= w_nrd;
         r_rdy <= w_nrdy;
      end
   end

   // Popcount of the registered valid bits equals the count of next-state bits
   // computed at the last non-hold edge.
   always_comb begin
      w_cnt = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         w_cnt = w_cnt + SW'(r_v[k]);
      end
   end

   assign inflight    = w_cnt;
   assign fwd_sel_rs1 = r_fwd1;
   assign fwd_sel_rs2 = r_fwd2;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard (DEPTH=3, FLUSH_AGE=2): issued instructions push
// their expected bypass selects to a queue, popped and compared in the EX cycle.
module tb_pipe_scoreboard;
   localparam int DEPTH     = 3;
   localparam int FLUSH_AGE = 2;
   localparam int LW        = 2;
   localparam int SW        = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [4:0]    id_rs1;
   logic [4:0]    id_rs2;
   logic          id_use_rs1;
   logic          id_use_rs2;
   logic [4:0]    id_rd;
   logic          id_we;
   logic [LW-1:0] id_rdy;
   logic          hold;
   logic          flush;
   logic          stall;
   logic [SW-1:0] fwd_sel_rs1;
   logic [SW-1:0] fwd_sel_rs2;
   logic [SW-1:0] inflight;

   typedef struct {
      string         tag;
      logic [SW-1:0] f1;
      logic [SW-1:0] f2;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   pipe_scoreboard #(.DEPTH(DEPTH), .FLUSH_AGE(FLUSH_AGE), .LW(LW), .SW(SW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
      .id_rdy(id_rdy), .hold(hold), .flush(flush), .stall(stall),
      .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2), .inflight(inflight)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic we,
                        input logic [LW-1:0] rdy);
      id_valid   = 1'b1;
      id_rs1     = rs1;
      id_rs2     = rs2;
      id_use_rs1 = u1;
      id_use_rs2 = u2;
      id_rd      = rd;
      id_we      = we;
      id_rdy     = rdy;
      #1;
   endtask

   task automatic idle();
      id_valid = 1'b0;
      #1;
   endtask

   task automatic drain();
      idle();
      repeat (DEPTH) tick();
   endtask

   // Issues whatever ID currently holds; it must not stall.
   task automatic issue(input string tag, input logic [SW-1:0] f1, input logic [SW-1:0] f2);
      exp_t e;
      chk({tag, "_nostall"}, 8'(stall), 8'd0);
      sb.push_back('{tag, f1, f2});
      tick();
      e = sb.pop_front();
      chk({e.tag, "_fwd1"}, 8'(fwd_sel_rs1), 8'(e.f1));
      chk({e.tag, "_fwd2"}, 8'(fwd_sel_rs2), 8'(e.f2));
   endtask

   initial begin
      rst = 1'b0; hold = 1'b0; flush = 1'b0;
      id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      id_rd = '0; id_we = 1'b0; id_rdy = '0;

      // reset state
      tick(); tick();
      drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 2'd2);
      chk("rst_stall", 8'(stall), 8'd0);
      chk("rst_inflight", 8'(inflight), 8'd0);
      chk("rst_fwd1", 8'(fwd_sel_rs1), 8'd0);
      chk("rst_fwd2", 8'(fwd_sel_rs2), 8'd0);
      rst = 1'b1;
      idle();
      tick();

      // ALU chain
      drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 2'd2);
      issue("add_x5", 2'd0, 2'd0);
      drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 2'd2);
      issue("sub_x7", 2'd2, 2'd2);
      drive(5'd5, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 2'd2);
      issue("or_x10", 2'd3, 2'd0);
      chk("alu_inflight", 8'(inflight), 8'd3);
      drain();
      chk("drain_inflight", 8'(inflight), 8'd0);

      // load-use
      drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 2'd3);
      issue("lw_x6", 2'd0, 2'd0);
      drive(5'd6, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 2'd2);
      chk("lu_stall", 8'(stall), 8'd1);
      tick();
      chk("lu_stall_once", 8'(stall), 8'd0);
      chk("lu_bubble_fwd1", 8'(fwd_sel_rs1), 8'd0);
      chk("lu_bubble_inflight", 8'(inflight), 8'd1);
      issue("add_x8", 2'd3, 2'd0);
      drain();

      // double writer: youngest producer decides
      drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 2'd2);
      issue("addi_x9", 2'd0, 2'd0);
      drive(5'd2, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 2'd3);
      issue("lw_x9", 2'd0, 2'd0);
      drive(5'd9, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, 2'd2);
      chk("dw_stall", 8'(stall), 8'd1);
      tick();
      issue("add_x11", 2'd3, 2'd3);
      drain();

      // x0 destination is inert
      drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'd3);
      issue("ld_x0", 2'd0, 2'd0);
      drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 2'd2);
      issue("use_x0", 2'd0, 2'd0);
      drain();

      // flush kills slots younger than FLUSH_AGE
      drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 2'd2);
      issue("addi_x12", 2'd0, 2'd0);
      drive(5'd2, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 2'd3);
      issue("lw_x6_f", 2'd0, 2'd0);
      drive(5'd6, 5'd12, 1'b1, 1'b1, 5'd13, 1'b1, 2'd2);
      flush = 1'b1;
      #1;
      chk("flush_stall", 8'(stall), 8'd0);
      tick();
      flush = 1'b0;
      #1;
      chk("flush_inflight", 8'(inflight), 8'd1);
      chk("flush_fwd1", 8'(fwd_sel_rs1), 8'd0);
      issue("post_flush", 2'd0, 2'd0);
      chk("post_flush_inflight", 8'(inflight), 8'd1);
      drain();

      // hold freezes state; flush under hold ignored
      drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'd2);
      issue("addi_x5_h", 2'd0, 2'd0);
      drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 2'd3);
      issue("lw_x6_h", 2'd2, 2'd0);
      drive(5'd6, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 2'd2);
      chk("hold_pre_stall", 8'(stall), 8'd1);
      hold = 1'b1;
      tick();
      chk("hold1_inflight", 8'(inflight), 8'd2);
      chk("hold1_fwd1", 8'(fwd_sel_rs1), 8'd2);
      chk("hold1_stall", 8'(stall), 8'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("hold2_inflight", 8'(inflight), 8'd2);
      chk("hold2_fwd1", 8'(fwd_sel_rs1), 8'd2);
      chk("hold2_stall", 8'(stall), 8'd1);
      tick();
      chk("hold3_inflight", 8'(inflight), 8'd2);
      chk("hold3_stall", 8'(stall), 8'd1);
      hold = 1'b0;
      #1;
      chk("unhold_stall", 8'(stall), 8'd1);
      tick();
      chk("unhold_bubble_fwd1", 8'(fwd_sel_rs1), 8'd0);
      issue("add_x8_h", 2'd3, 2'd0);
      drain();

      // reset mid-run
      drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'd2);
      issue("r_addi_x5", 2'd0, 2'd0);
      drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 2'd2);
      issue("r_addi_x6", 2'd0, 2'd0);
      drive(5'd6, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 2'd3);
      issue("r_lw_x7", 2'd2, 2'd0);
      chk("r_inflight3", 8'(inflight), 8'd3);
      drive(5'd7, 5'd6, 1'b1, 1'b1, 5'd14, 1'b1, 2'd2);
      chk("r_pre_stall", 8'(stall), 8'd1);
      rst = 1'b0;
      #1;
      chk("r_low_stall", 8'(stall), 8'd0);
      tick();
      rst = 1'b1;
      #1;
      chk("r_inflight0", 8'(inflight), 8'd0);
      chk("r_fwd1_0", 8'(fwd_sel_rs1), 8'd0);
      chk("r_fwd2_0", 8'(fwd_sel_rs2), 8'd0);
      issue("r_post", 2'd0, 2'd0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
